// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder returning one RV32IC instruction per halfword-aligned fetch
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_req,
    input  logic [31:0]                    i_addr,
    input  logic                           i_flush,
    output logic                           o_ready,
    output logic                           o_valid,
    output logic [31:0]                    o_instr,
    output logic [31:0]                    o_addr,
    output logic                           o_len2,
    output logic                           o_fault,
    input  logic                           i_we,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_waddr,
    input  logic [31:0]                    i_wdata
);

    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [2:0] LAT = 3'(LATENCY);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [31:0]     addr_q, addr_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [15:0]     half_q, half_d;
    logic [31:0]     instr_q, instr_d;
    logic [31:0]     oaddr_q, oaddr_d;
    logic            len2_q, len2_d;
    logic            fault_q, fault_d;

    logic [31:0]     mem_q [DEPTH_WORDS];
    logic [31:0]     req_addr;
    logic [31:0]     req_idx;
    logic [31:0]     rd_word;
    logic            last_word;

    // Store is never reset; the load port stays live in every state.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign req_addr  = {i_addr[31:1], 1'b0};
    assign req_idx   = (req_addr - BASE_ADDR) >> 2;
    assign rd_word   = mem_q[(state_q == RD1) ? idx_q + AW'(1) : idx_q];
    assign last_word = (idx_q == AW'(DEPTH_WORDS - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        idx_d   = idx_q;
        half_d  = half_q;
        instr_d = instr_q;
        oaddr_d = oaddr_q;
        len2_d  = len2_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (i_req && !i_flush) begin
                    addr_d = req_addr;
                    idx_d  = req_idx[AW-1:0];
                    cnt_d  = LAT;
                    if (req_idx >= 32'(DEPTH_WORDS)) begin
                        instr_d = 32'h0;
                        oaddr_d = req_addr;
                        len2_d  = 1'b0;
                        fault_d = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = RD0;
                    end
                end
            end
            RD0, RD1: begin
                cnt_d = cnt_q - 3'd1;
                if (i_flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 3'd1) begin
                    oaddr_d = addr_q;
                    fault_d = 1'b0;
                    state_d = RESP;
                    if (state_q == RD1) begin
                        instr_d = {rd_word[15:0], half_q};
                        len2_d  = 1'b0;
                    end else if (!addr_q[1]) begin
                        instr_d = (rd_word[1:0] == 2'b11) ? rd_word : {16'h0, rd_word[15:0]};
                        len2_d  = (rd_word[1:0] != 2'b11);
                    end else if (rd_word[17:16] != 2'b11) begin
                        instr_d = {16'h0, rd_word[31:16]};
                        len2_d  = 1'b1;
                    end else if (last_word) begin
                        // 32-bit opcode in the top halfword of the store has no second half.
                        instr_d = 32'h0;
                        len2_d  = 1'b0;
                        fault_d = 1'b1;
                    end else begin
                        half_d  = rd_word[31:16];
                        cnt_d   = LAT;
                        state_d = RD1;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 32'h0;
            idx_q   <= '0;
            half_q  <= 16'h0;
            instr_q <= 32'h0;
            oaddr_q <= 32'h0;
            len2_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            half_q  <= half_d;
            instr_q <= instr_d;
            oaddr_q <= oaddr_d;
            len2_q  <= len2_d;
            fault_q <= fault_d;
        end
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = (state_q == RESP) & ~i_flush;
    assign o_instr = instr_q;
    assign o_addr  = oaddr_q;
    assign o_len2  = len2_q;
    assign o_fault = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder (LATENCY=2, 16-word store at 0x1000)
module tb_imem_responder;

    localparam int          L    = 2;
    localparam int          D    = 16;
    localparam logic [31:0] BASE = 32'h0000_1000;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        len2;
        logic        fault;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        i_reset, i_req, i_flush, i_we;
    logic [31:0] i_addr, i_wdata;
    logic [3:0]  i_waddr;
    logic        o_ready, o_valid, o_len2, o_fault;
    logic [31:0] o_instr, o_addr;

    exp_t        sb[$];
    logic [31:0] mem_m [D];
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    imem_responder #(.DEPTH_WORDS(D), .LATENCY(L), .BASE_ADDR(BASE)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .o_ready(o_ready), .o_valid(o_valid), .o_instr(o_instr), .o_addr(o_addr),
        .o_len2(o_len2), .o_fault(o_fault),
        .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every o_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'(o_valid), 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("instr", o_instr, e.instr);
                check("addr", o_addr, e.addr);
                check("fault", 32'(o_fault), 32'(e.fault));
                if (!e.fault) check("len2", 32'(o_len2), 32'(e.len2));
                check("valid_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic loadw(input int idx, input logic [31:0] d);
        i_we = 1'b1; i_waddr = 4'(idx); i_wdata = d; mem_m[idx] = d;
        @(posedge clk); #1;
        i_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] ins, input logic l2,
                         input logic f, input int lat, input bit push);
        exp_t e;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = a;
        if (push) begin
            e.instr = ins; e.addr = {a[31:1], 1'b0}; e.len2 = l2; e.fault = f; e.cyc = cyc + lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (o_ready === 1'b1) ok = 1'b1;
        end
        if (!ok) check("ready_timeout", 32'h0, 32'h1);
    endtask

    // Independent reference for a fetch at byte address a against the shadow store.
    task automatic model_issue(input logic [31:0] a);
        logic [31:0] idx, w, w1;
        idx = ({a[31:1], 1'b0} - BASE) >> 2;
        if (idx >= D) begin
            issue(a, 32'h0, 1'b0, 1'b1, 1, 1'b1);
        end else begin
            w = mem_m[idx];
            if (!a[1] && w[1:0] == 2'b11)       issue(a, w, 1'b0, 1'b0, L + 1, 1'b1);
            else if (!a[1])                     issue(a, {16'h0, w[15:0]}, 1'b1, 1'b0, L + 1, 1'b1);
            else if (w[17:16] != 2'b11)         issue(a, {16'h0, w[31:16]}, 1'b1, 1'b0, L + 1, 1'b1);
            else if (idx == D - 1)              issue(a, 32'h0, 1'b0, 1'b1, L + 1, 1'b1);
            else begin
                w1 = mem_m[idx + 1];
                issue(a, {w1[15:0], w[31:16]}, 1'b0, 1'b0, 2 * L + 1, 1'b1);
            end
        end
        wait_ready();
    endtask

    initial begin
        i_reset = 1'b1; i_req = 1'b0; i_flush = 1'b0; i_we = 1'b0;
        i_addr = 32'h0; i_wdata = 32'h0; i_waddr = 4'h0;
        @(posedge clk); #1;
        // Store loads land even while reset is held.
        loadw(0, 32'h0050_0093);
        loadw(1, 32'h4505_0505);
        loadw(2, 32'h0093_4501);
        loadw(3, 32'h1234_0050);
        loadw(15, 32'hABC3_1234);
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(o_ready), 32'h1);
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_addr", o_addr, 32'h0);
        check("rst_len2_fault", {30'h0, o_len2, o_fault}, 32'h0);

        issue(BASE + 32'h0, 32'h0050_0093, 1'b0, 1'b0, L + 1, 1'b1); wait_ready();
        issue(BASE + 32'h4, 32'h0000_0505, 1'b1, 1'b0, L + 1, 1'b1); wait_ready();
        issue(BASE + 32'h6, 32'h0000_4505, 1'b1, 1'b0, L + 1, 1'b1); wait_ready();
        issue(BASE + 32'hA, 32'h0050_0093, 1'b0, 1'b0, 2 * L + 1, 1'b1); wait_ready();
        issue(BASE + 32'h40, 32'h0, 1'b0, 1'b1, 1, 1'b1); wait_ready();
        issue(BASE + 32'h3E, 32'h0, 1'b0, 1'b1, L + 1, 1'b1); wait_ready();
        issue(BASE + 32'h3C, 32'h0000_1234, 1'b1, 1'b0, L + 1, 1'b1); wait_ready();
        issue(32'h0000_0000, 32'h0, 1'b0, 1'b1, 1, 1'b1); wait_ready();
        issue(BASE + 32'h5, 32'h0000_0505, 1'b1, 1'b0, L + 1, 1'b1); wait_ready();

        // Flush in the first read cycle: back to idle next cycle, no response.
        issue(BASE, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        @(negedge clk);
        check("flush_rd_ready", 32'(o_ready), 32'h1);
        issue(BASE + 32'h4, 32'h0000_0505, 1'b1, 1'b0, L + 1, 1'b1); wait_ready();

        // Flush during the response cycle masks o_valid.
        issue(BASE + 32'h4, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        repeat (L) @(posedge clk);
        #1 i_flush = 1'b1;
        @(negedge clk);
        check("flush_resp_valid", 32'(o_valid), 32'h0);
        @(posedge clk); #1;
        i_flush = 1'b0;
        wait_ready();

        // Flush and request together in idle: not accepted.
        @(posedge clk); #1;
        i_req = 1'b1; i_flush = 1'b1; i_addr = BASE;
        @(posedge clk); #1;
        i_req = 1'b0; i_flush = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", 32'(o_ready), 32'h1);
        repeat (4) @(posedge clk);

        // Reset in the first RD1 cycle of a straddling fetch.
        issue(BASE + 32'hA, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        repeat (L) @(posedge clk);
        #1 i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        @(negedge clk);
        check("rd1_rst_ready", 32'(o_ready), 32'h1);
        check("rd1_rst_valid", 32'(o_valid), 32'h0);
        check("rd1_rst_instr", o_instr, 32'h0);
        check("rd1_rst_addr", o_addr, 32'h0);
        repeat (2 * L + 2) @(posedge clk);

        // Load-port write on the read cycle of word 0 returns the old word.
        issue(BASE, 32'h0050_0093, 1'b0, 1'b0, L + 1, 1'b1);
        repeat (L - 1) @(posedge clk);
        #1 loadw(0, 32'hDEAD_4501);
        wait_ready();
        issue(BASE, 32'h0000_4501, 1'b1, 1'b0, L + 1, 1'b1); wait_ready();

        for (int i = 0; i < D; i++) loadw(i, $urandom);
        for (int i = 0; i < 10; i++) model_issue(BASE + 32'(2 * $urandom_range(0, 2 * D - 1)));

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
